// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
package pipe_pkg;

    localparam int unsigned STALL_CNT_W = 32;

    localparam logic [STALL_CNT_W-1:0] BEAT_CNT_RST = '0;

    // Bits needed to count every stage plus the skid entry (0..STAGES+1).
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Valid/ready handshake bundle for pipe_chain: upstream side, downstream side and flush.
interface pipe_chain_if #(
    parameter int unsigned WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_chain_skid_buffer.sv
// One-entry skid buffer in front of stage 0; in_ready comes straight from a flop.
module skid_buffer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    input  logic             take,
    output logic             in_ready,
    output logic             fwd_valid_c,
    output logic [WIDTH-1:0] fwd_data_c,
    output logic             sk_vld_nxt_c
);

    logic             sk_vld;
    logic [WIDTH-1:0] sk_dat;
    logic             in_fire_c;
    logic             fill_c;

    // Beats seen during flush are dropped before they reach any storage.
    assign in_fire_c = in_valid & in_ready & ~flush;

    always_comb begin
        sk_vld_nxt_c = sk_vld;
        fill_c       = 1'b0;
        fwd_valid_c  = sk_vld | in_fire_c;
        fwd_data_c   = sk_vld ? sk_dat : in_data;
        if (flush) begin
            sk_vld_nxt_c = 1'b0;
        end else if (sk_vld && take) begin
            sk_vld_nxt_c = 1'b0;
        end else if (in_fire_c && !take) begin
            sk_vld_nxt_c = 1'b1;
            fill_c       = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sk_vld   <= 1'b0;
            sk_dat   <= '0;
            in_ready <= 1'b1;
        end else begin
            sk_vld   <= sk_vld_nxt_c;
            in_ready <= ~sk_vld_nxt_c;
            if (fill_c) begin
                sk_dat <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Elastic valid/ready register chain with flush and a registered-ready skid input.
// Define PIPE_CHAIN_STATS_EN to enable stall/beat counters and the report display.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CORE   = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    pipe_chain_if.slave                    bus,
    output logic [occ_width(STAGES)-1:0]   occupancy,
    input  logic                           report,
    output logic [STALL_CNT_W-1:0]         stall_count
);

    localparam int unsigned OCC_W = occ_width(STAGES);

    logic [STAGES-1:0] vld_nxt;
    logic              fwd_valid_c;
    logic [WIDTH-1:0]  fwd_data_c;
    logic              sk_vld_nxt_c;
    logic [OCC_W-1:0]  occ_nxt;

    skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (bus.in_valid),
        .in_data      (bus.in_data),
        .flush        (bus.flush),
        .take         (g_stage[0].adv),
        .in_ready     (bus.in_ready),
        .fwd_valid_c  (fwd_valid_c),
        .fwd_data_c   (fwd_data_c),
        .sk_vld_nxt_c (sk_vld_nxt_c)
    );

    // A stage advances when any stage downstream of it can move or holds a bubble.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             adv;
        logic             vld_q;
        logic [WIDTH-1:0] dat_q;
        logic             src_vld;
        logic [WIDTH-1:0] src_dat;

        if (i == STAGES - 1) begin : g_last
            assign adv = bus.out_ready | ~vld_q;
        end else begin : g_mid
            assign adv = g_stage[i+1].adv | ~vld_q;
        end

        if (i == 0) begin : g_head
            assign src_vld = fwd_valid_c;
            assign src_dat = fwd_data_c;
        end else begin : g_tail
            assign src_vld = g_stage[i-1].vld_q;
            assign src_dat = g_stage[i-1].dat_q;
        end

        assign vld_nxt[i] = bus.flush ? 1'b0 : (adv ? src_vld : vld_q);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_nxt[i];
                if (adv) begin
                    dat_q <= src_dat;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].vld_q;
    assign bus.out_data  = g_stage[STAGES-1].dat_q;

    assign occ_nxt = OCC_W'($countones(vld_nxt)) + OCC_W'(sk_vld_nxt_c);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_nxt;
        end
    end

`ifdef PIPE_CHAIN_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W-1:0] beat_q;

    // Stall count saturates; only reset clears it, flush leaves it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            beat_q  <= BEAT_CNT_RST;
        end else begin
            if (bus.out_valid && !bus.out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_CNT_W'(1);
            end
            if (bus.out_valid && bus.out_ready) begin
                beat_q <= beat_q + STALL_CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_q;

    always @(posedge clock) begin
        if (reset && report) begin
            $display("Core [%0d] pipe_chain beats=%0d stalls=%0d", CORE, beat_q, stall_q);
        end
    end
`else
    localparam int unsigned UNUSED_CORE = CORE;
    logic unused_report;

    assign unused_report = report;
    assign stall_count   = '0;
`endif

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised elastic pipeline register chain. It replaces fixed-depth `delay` registers between core stages with a valid/ready handshake, per-stage valid bits, synchronous flush and a registered-ready input skid buffer. Instantiated between fetch/decode/execute/memory/writeback boundaries so a stall propagates backpressure instead of relying on a global stall wire.

## Interface
Parameters:
- `WIDTH`, 32, payload bits per beat (≥1)
- `STAGES`, 2, register stages in the chain (≥1)
- `CORE`, 0, core index, used only in report text

Ports:
- `clock`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `in_valid`  in  1  upstream beat present
- `in_ready`  out  1  chain can accept a beat; driven only from registers
- `in_data`  in  WIDTH  upstream payload
- `flush`  in  1  synchronous kill of all held beats
- `out_valid`  out  1  oldest beat present at last stage
- `out_ready`  in  1  downstream accepts
- `out_data`  out  WIDTH  payload of last stage
- `occupancy`  out  $clog2(STAGES+2)  beats held (stages + skid)
- `report`  in  1  performance-report strobe
- `stall_count`  out  32  cycles with out_valid=1 and out_ready=0

## Operation
- State: `vld[i]`/`dat[i]` for i=0..STAGES-1; skid entry `sk_vld`/`sk_dat`.
- Handshake: transfer on a side when valid and ready are both 1 at a rising edge. valid must not drop and data must not change until the transfer.
- `adv[STAGES-1] = out_ready | ~vld[STAGES-1]`. `adv[i] = adv[i+1] | ~vld[i]`. This is a combinational chain inside the block and never reaches `in_ready`.
- Stage i>0 loads `dat[i-1]` when `adv[i]`. `vld[i] <= vld[i-1]` when `adv[i]`, otherwise it holds.
- Stage 0 source priority: skid if `sk_vld`, otherwise `in_data`.
- Skid fills when an input transfer occurs and stage 0 cannot take it (`~adv[0]`, or `sk_vld` already being drained). It empties when stage 0 loads from it.
- `in_ready = ~sk_vld`, so at most one beat is ever in the skid.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush.
- Flush:
  - At the edge, clears all `vld[i]` and `sk_vld`.
  - An input beat presented in the flush cycle is discarded even if `in_ready=1`.
  - An output transfer in the flush cycle completes and counts as delivered.
- `occupancy` = popcount(vld) + sk_vld, with the maximum STAGES+1.
- `stall_count` saturates at 2^32-1. Only reset clears it; flush does not.
- Reset values: `vld`=0, `dat`=0, skid empty, `in_ready`=1, `out_valid`=0, `out_data`=0, `occupancy`=0, `stall_count`=0.

## Timing
- Latency with no backpressure: a beat accepted at edge t is on `out_data` with `out_valid`=1 after edge t+STAGES-1, i.e. STAGES cycles of register delay.
- Throughput is 1 beat/cycle sustained when `out_ready`=1.
- Backpressure: after `out_ready` falls, `in_ready` falls no earlier than the edge at which the skid fills. Capacity before `in_ready`=0 is STAGES+1 beats.
- Simultaneous fill of a stage and drain of the same stage in one cycle is legal; the stage stays valid with new data.
- Reset assertion mid-transfer clears everything immediately, with no handshake completion.

## Configuration
- `PIPE_CHAIN_STATS_EN` defined:
  - `stall_count` counts as above.
  - An additional internal 32-bit beat counter counts output transfers.
  - On each rising edge with `report`=1, the block `$display`s "Core [CORE] pipe_chain beats=%d stalls=%d".
- Not defined: `stall_count` is tied to 0, no counters exist and no display occurs. Datapath behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - occupancy-width helper function
  - `STALL_CNT_W`=32 constant
  - beat-counter reset constant
- One natural sub-module: `skid_buffer` (one entry, registered ready). Instantiated once, in front of stage 0.
- Stage registers are a generate loop in the top module.

## Test plan
- Reset then stream 8 beats 0x1..0x8, `out_ready`=1, STAGES=2: first `out_valid` two cycles after first accept; outputs 0x1..0x8 in order, one per cycle; `occupancy` peaks at 2.
- Hold `out_ready`=0, drive `in_valid`=1 continuously: `in_ready` drops after exactly STAGES+1=3 accepted beats; `occupancy`=3; `stall_count` increments each cycle `out_valid`=1.
- Release `out_ready` after the previous fill: 3 held beats drain in order in 3 cycles; no beat lost or duplicated; `in_ready` returns to 1 within 1 cycle of the skid emptying.
- Flush with 3 beats held and `in_valid`=1 carrying 0xAA: next cycle `out_valid`=0, `occupancy`=0; 0xAA never appears at the output.
- Assert `reset`=0 asynchronously between edges while full: outputs are at reset values before the next edge; `in_ready`=1 after release.
- With `PIPE_CHAIN_STATS_EN`, pulse `report` after 8 transfers and 5 stall cycles: display shows beats=8 stalls=5. Without the macro, `stall_count` stays 0.
